// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and default sizes for the memory-channel arbiter.
// The optional round-robin grant is selected by MEM_ARB_RR_EN.
package mem_arbiter_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t S_IDLE  = 2'd0;
  localparam arb_state_t S_REQ   = 2'd1;
  localparam arb_state_t S_WDATA = 2'd2;
  localparam arb_state_t S_RDATA = 2'd3;

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 128;
  localparam int BEATS_DEF  = 4;

endpackage

// File: rtl/mem_arb_select.sv
// Two-way grant between icache and dcache miss requests.
// MEM_ARB_RR_EN selects round-robin; otherwise dcache has fixed priority.
module mem_arb_select
  import mem_arbiter_pkg::*;
(
  input  logic i_ic_valid,
  input  logic i_dc_valid,
`ifdef MEM_ARB_RR_EN
  input  logic i_last,
`endif
  output logic o_gnt_ic,
  output logic o_gnt_dc
);

`ifdef MEM_ARB_RR_EN
  logic w_both;

  assign w_both = i_ic_valid & i_dc_valid;

  // On a tie the side that did not win last time goes first
  assign o_gnt_dc = i_dc_valid & (~w_both | (i_last == OWN_IC));
  assign o_gnt_ic = i_ic_valid & (~w_both | (i_last == OWN_DC));
`else
  assign o_gnt_dc = i_dc_valid;
  assign o_gnt_ic = i_ic_valid & ~i_dc_valid;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares the main-memory refill/writeback channel between icache and dcache.
// Define MEM_ARB_RR_EN for round-robin grants (default: dcache priority).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int BEATS  = BEATS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req_valid,
  output logic              ic_req_ready,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_resp_valid,
  input  logic              dc_req_valid,
  output logic              dc_req_ready,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic              dc_req_rw,
  input  logic              dc_wdata_valid,
  output logic              dc_wdata_ready,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_last,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_rw,
  output logic              mem_wdata_valid,
  input  logic              mem_wdata_ready,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              busy
);

  localparam int CW = $clog2(BEATS);
  localparam logic [CW-1:0] CNT_LAST = CW'(BEATS - 1);

  arb_state_t        r_state;
  logic              r_owner;
  logic [CW-1:0]     r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rw;

  logic w_idle;
  logic w_wst;
  logic w_rst;
  logic w_gnt_ic;
  logic w_gnt_dc;
  logic w_wbeat;
  logic w_rbeat;
  logic w_cnt_last;

  assign w_idle     = (r_state == S_IDLE);
  assign w_wst      = (r_state == S_WDATA);
  assign w_rst      = (r_state == S_RDATA);
  assign w_cnt_last = (r_cnt == CNT_LAST);

`ifdef MEM_ARB_RR_EN
  logic r_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= OWN_DC;
    end else if (ic_req_ready | dc_req_ready) begin
      r_last <= dc_req_ready ? OWN_DC : OWN_IC;
    end
  end
`endif

  mem_arb_select u_sel (
    .i_ic_valid (ic_req_valid),
    .i_dc_valid (dc_req_valid),
`ifdef MEM_ARB_RR_EN
    .i_last     (r_last),
`endif
    .o_gnt_ic   (w_gnt_ic),
    .o_gnt_dc   (w_gnt_dc)
  );

  assign ic_req_ready = w_idle & w_gnt_ic;
  assign dc_req_ready = w_idle & w_gnt_dc;

  assign mem_req_valid = (r_state == S_REQ);
  assign mem_req_addr  = r_addr;
  assign mem_req_rw    = r_rw;

  assign mem_wdata_valid = w_wst & dc_wdata_valid;
  assign dc_wdata_ready  = w_wst & mem_wdata_ready;
  assign mem_wdata       = w_wst ? dc_wdata : '0;
  assign w_wbeat         = w_wst & dc_wdata_valid & mem_wdata_ready;

  // Read beats cannot be stalled, so every valid beat is consumed
  assign w_rbeat       = w_rst & mem_resp_valid;
  assign ic_resp_valid = w_rbeat & (r_owner == OWN_IC);
  assign dc_resp_valid = w_rbeat & (r_owner == OWN_DC);
  assign resp_data     = w_rst ? mem_resp_data : '0;
  assign resp_last     = w_rbeat & w_cnt_last;

  assign busy = ~w_idle;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_owner <= OWN_IC;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_rw    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (ic_req_ready | dc_req_ready) begin
            r_state <= S_REQ;
            r_owner <= dc_req_ready ? OWN_DC : OWN_IC;
            r_addr  <= dc_req_ready ? dc_req_addr : ic_req_addr;
            r_rw    <= dc_req_ready & dc_req_rw;
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            r_state <= r_rw ? S_WDATA : S_RDATA;
          end
        end
        S_WDATA: begin
          if (w_wbeat) begin
            if (w_cnt_last) begin
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_RDATA: begin
          if (w_rbeat) begin
            if (w_cnt_last) begin
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus burst sequences
// with response/write-beat scoreboards.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 128;
  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ic_req_valid, ic_req_ready, ic_resp_valid;
  logic [AW-1:0] ic_req_addr;
  logic          dc_req_valid, dc_req_ready, dc_req_rw;
  logic [AW-1:0] dc_req_addr;
  logic          dc_wdata_valid, dc_wdata_ready, dc_resp_valid;
  logic [DW-1:0] dc_wdata, resp_data, mem_wdata, mem_resp_data;
  logic          resp_last, mem_req_valid, mem_req_ready, mem_req_rw;
  logic [AW-1:0] mem_req_addr;
  logic          mem_wdata_valid, mem_wdata_ready, mem_resp_valid, busy;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BEATS(NB)) dut (
    .clk             (clk),
    .reset           (reset),
    .ic_req_valid    (ic_req_valid),
    .ic_req_ready    (ic_req_ready),
    .ic_req_addr     (ic_req_addr),
    .ic_resp_valid   (ic_resp_valid),
    .dc_req_valid    (dc_req_valid),
    .dc_req_ready    (dc_req_ready),
    .dc_req_addr     (dc_req_addr),
    .dc_req_rw       (dc_req_rw),
    .dc_wdata_valid  (dc_wdata_valid),
    .dc_wdata_ready  (dc_wdata_ready),
    .dc_wdata        (dc_wdata),
    .dc_resp_valid   (dc_resp_valid),
    .resp_data       (resp_data),
    .resp_last       (resp_last),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_addr    (mem_req_addr),
    .mem_req_rw      (mem_req_rw),
    .mem_wdata_valid (mem_wdata_valid),
    .mem_wdata_ready (mem_wdata_ready),
    .mem_wdata       (mem_wdata),
    .mem_resp_valid  (mem_resp_valid),
    .mem_resp_data   (mem_resp_data),
    .busy            (busy)
  );

  int checks = 0;
  int fails  = 0;
  int nwr    = 0;
  logic m_last = OWN_DC;

  typedef struct {
    logic          own_dc;
    logic [DW-1:0] data;
    logic          last;
  } rexp_t;

  typedef struct {
    logic ic;
    logic dc;
    logic rv;
    logic eic;
    logic edc;
  } vec_t;

  rexp_t         rq[$];
  logic [DW-1:0] wq[$];
  rexp_t         m_e;
  logic [DW-1:0] m_w;
  vec_t          tv[6];
  logic [DW-1:0] wd[4];

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [9:0] ovec();
    return {ic_req_ready, dc_req_ready, ic_resp_valid, dc_resp_valid,
            resp_last, mem_req_valid, mem_req_rw, mem_wdata_valid,
            dc_wdata_ready, busy};
  endfunction

  // Scoreboard: read beats and write beats as seen by the consumer
  always @(negedge clk) begin
    if (!reset) begin
      if (ic_resp_valid || dc_resp_valid) begin
        checks++;
        if (rq.size() == 0) begin
          fails++;
          $display("FAIL resp_unexpected: got %0h want none", resp_data);
        end else begin
          m_e = rq.pop_front();
          chk("resp_own_dc", dc_resp_valid, m_e.own_dc);
          chk("resp_own_ic", ic_resp_valid, !m_e.own_dc);
          chk("resp_data", resp_data, m_e.data);
          chk("resp_last", resp_last, m_e.last);
        end
      end
      if (mem_wdata_valid && mem_wdata_ready) begin
        checks++;
        if (wq.size() == 0) begin
          fails++;
          $display("FAIL wr_unexpected: got %0h want none", mem_wdata);
        end else begin
          m_w = wq.pop_front();
          chk("wr_data", mem_wdata, m_w);
          nwr++;
        end
      end
    end
  end

  task automatic do_txn(input logic exp_dc, input logic [AW-1:0] exp_addr,
                        input int stall, input logic hold,
                        input logic [7:0] dbase, input int nbeats);
    @(negedge clk);
    chk("gnt_dc", dc_req_ready, exp_dc);
    chk("gnt_ic", ic_req_ready, !exp_dc);
    @(posedge clk); #1;
    if (!hold) begin
      ic_req_valid = 1'b0;
      dc_req_valid = 1'b0;
    end
    m_last = exp_dc;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_req_valid", mem_req_valid, 1);
      chk("stall_req_addr", mem_req_addr, exp_addr);
      chk("stall_no_ready", {ic_req_ready, dc_req_ready}, 0);
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("req_valid", mem_req_valid, 1);
    chk("req_addr", mem_req_addr, exp_addr);
    chk("req_rw", mem_req_rw, 0);
    chk("req_busy", busy, 1);
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = DW'(dbase) + DW'(i);
      rq.push_back('{exp_dc, mem_resp_data, (i == NB - 1)});
      @(posedge clk); #1;
    end
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic exp_dc;
    logic hs;
    int   k;

    tv[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`ifdef MEM_ARB_RR_EN
    tv[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
`else
    tv[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
`endif
    tv[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    wd[0] = {32'h1111_0000, 96'h0};
    wd[1] = 128'h2222_3333_4444_5555_6666_7777_8888_9999;
    wd[2] = 128'hDEAD_BEEF;
    wd[3] = {64'hCAFE_F00D, 64'h0123_4567};

    ic_req_valid = 0; ic_req_addr = '0;
    dc_req_valid = 0; dc_req_addr = '0; dc_req_rw = 0;
    dc_wdata_valid = 0; dc_wdata = '0;
    mem_req_ready = 0; mem_wdata_ready = 0;
    mem_resp_valid = 0; mem_resp_data = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", ovec(), 0);
    chk("rst_addr", mem_req_addr, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Combinational grant / stray-beat table in IDLE; valids drop before the edge
    foreach (tv[v]) begin
      @(posedge clk); #1;
      ic_req_valid   = tv[v].ic;
      dc_req_valid   = tv[v].dc;
      mem_resp_valid = tv[v].rv;
      ic_req_addr    = 32'h100 + 32'(v);
      dc_req_addr    = 32'h200 + 32'(v);
      mem_resp_data  = 128'hBAD0 + 128'(v);
      @(negedge clk);
      chk("tv_ic_ready", ic_req_ready, tv[v].eic);
      chk("tv_dc_ready", dc_req_ready, tv[v].edc);
      chk("tv_resp", {ic_resp_valid, dc_resp_valid, resp_last}, 0);
      chk("tv_busy", busy, 0);
      #1;
      ic_req_valid = 0; dc_req_valid = 0; mem_resp_valid = 0;
    end

    // Dcache writeback with toggling memory backpressure
    @(posedge clk); #1;
    dc_req_valid = 1; dc_req_addr = 32'h2000; dc_req_rw = 1;
    @(negedge clk);
    chk("wb_dc_ready", dc_req_ready, 1);
    chk("wb_ic_ready", ic_req_ready, 0);
    @(posedge clk); #1;
    dc_req_valid = 0; dc_req_rw = 0; m_last = OWN_DC;
    mem_req_ready = 1;
    @(negedge clk);
    chk("wb_req_valid", mem_req_valid, 1);
    chk("wb_req_addr", mem_req_addr, 32'h2000);
    chk("wb_req_rw", mem_req_rw, 1);
    @(posedge clk); #1;
    mem_req_ready = 0;
    k = 0;
    dc_wdata = wd[0]; dc_wdata_valid = 1; wq.push_back(wd[0]);
    for (int c = 0; c < 7; c++) begin
      mem_wdata_ready = (c % 2 == 0);
      @(negedge clk);
      chk("wb_wdata_ready", dc_wdata_ready, mem_wdata_ready);
      hs = dc_wdata_valid & dc_wdata_ready;
      @(posedge clk); #1;
      if (hs) begin
        k++;
        if (k < 4) begin
          dc_wdata = wd[k];
          wq.push_back(wd[k]);
        end else begin
          dc_wdata_valid = 0;
        end
      end
    end
    mem_wdata_ready = 0;
    @(negedge clk);
    chk("wb_idle", busy, 0);
    chk("wb_beats", nwr, 4);
    chk("wb_queue", wq.size(), 0);

    // Single icache read, memory accepts on the second request cycle
    @(posedge clk); #1;
    ic_req_valid = 1; ic_req_addr = 32'h0000_1000;
    do_txn(OWN_IC, 32'h1000, 1, 0, 8'hA0, NB);
    @(negedge clk);
    chk("ic_busy_drop", busy, 0);
    chk("ic_queue", rq.size(), 0);

    // Three back-to-back rounds with both requesters asserted
    @(posedge clk); #1;
    ic_req_valid = 1; ic_req_addr = 32'h5000;
    dc_req_valid = 1; dc_req_addr = 32'h6000; dc_req_rw = 0;
    for (int r = 0; r < 3; r++) begin
`ifdef MEM_ARB_RR_EN
      exp_dc = (m_last == OWN_IC);
`else
      exp_dc = 1'b1;
`endif
      do_txn(exp_dc, exp_dc ? 32'h6000 : 32'h5000, 0, 1, 8'(16 * (r + 1)), NB);
    end
    ic_req_valid = 0; dc_req_valid = 0;
    @(negedge clk);
    chk("rr_idle", busy, 0);

    // Memory holds off the request for 10 cycles
    @(posedge clk); #1;
    ic_req_valid = 1; ic_req_addr = 32'h7000;
    do_txn(OWN_IC, 32'h7000, 10, 0, 8'hC0, NB);
    @(negedge clk);
    chk("stall_idle", busy, 0);

    // Stray response beat while idle
    @(posedge clk); #1;
    mem_resp_valid = 1; mem_resp_data = 128'hDEAD;
    @(negedge clk);
    chk("stray_resp", {ic_resp_valid, dc_resp_valid, resp_last}, 0);
    chk("stray_busy", busy, 0);
    @(posedge clk); #1;
    mem_resp_valid = 0;
    @(negedge clk);
    chk("stray_after", busy, 0);

    // Asynchronous reset in the middle of a read burst
    @(posedge clk); #1;
    ic_req_valid = 1; ic_req_addr = 32'h4000;
    do_txn(OWN_IC, 32'h4000, 0, 0, 8'hB0, 2);
    mem_resp_valid = 1; mem_resp_data = 128'hB2;
    mem_wdata_ready = 1;
    #1;
    chk("mid_busy", busy, 1);
    chk("mid_ic_resp", ic_resp_valid, 1);
    reset = 1'b1;
    #1;
    chk("arst_outputs", ovec(), 0);
    chk("arst_data", resp_data, 0);
    chk("arst_addr", mem_req_addr, 0);
    mem_resp_valid = 0; mem_resp_data = '0; mem_wdata_ready = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_last = OWN_DC;
    ic_req_valid = 1; ic_req_addr = 32'h3000;
    do_txn(OWN_IC, 32'h3000, 0, 0, 8'hD0, NB);
    @(negedge clk);
    chk("post_rst_idle", busy, 0);
    chk("final_rq", rq.size(), 0);
    chk("final_wq", wq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
